// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants, state encodings and helpers
package i2c_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int BIT_CNT_W     = 3;

    // Byte receiver states; shared so other I2C slave blocks decode identically.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECEIVE  = 2'd1,
        ST_ACK      = 2'd2,
        ST_ACK_HOLD = 2'd3
    } rx_state_e;

    // MSB-first reception: each new bit enters at bit 0.
    function automatic logic [BITS_PER_BYTE-1:0] shift_in_lsb(
        input logic [BITS_PER_BYTE-1:0] sr,
        input logic                     b
    );
        return {sr[BITS_PER_BYTE-2:0], b};
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - scl edge and START/STOP condition detector
module i2c_bus_monitor (
    input  logic clock,
    input  logic reset_n,
    input  logic scl,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl_q;
    logic sda_q;

    // One-clock history of the bus lines; idle bus level is high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl;
            sda_q <= sda_in;
        end
    end

    // START/STOP are sda transitions while scl stays high across both samples.
    always_comb begin
        scl_rise = !scl_q & scl;
        scl_fall = scl_q & !scl;
        start    = scl & scl_q & sda_q & !sda_in;
        stop     = scl & scl_q & !sda_q & sda_in;
    end

endmodule

// File: rtl/i2c_slave_read_byte.sv
// rtl/i2c_slave_read_byte.sv - I2C slave single-byte receiver with ACK/NACK
module i2c_slave_read_byte
    import i2c_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ack_enable,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] data,
    output logic       finish,
    output logic       error
);

    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_bus_monitor u_bus_monitor (
        .clock    (clock),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    rx_state_e                state;
    rx_state_e                state_n;
    logic [BIT_CNT_W-1:0]     bit_cnt;
    logic [BIT_CNT_W-1:0]     bit_cnt_n;
    logic                     byte_full;
    logic                     byte_full_n;
    logic [BITS_PER_BYTE-1:0] shift_reg;
    logic [BITS_PER_BYTE-1:0] shift_reg_n;
    logic                     ack_latched;
    logic                     ack_latched_n;
    logic [BITS_PER_BYTE-1:0] data_n;
    logic                     sda_out_n;
    logic                     finish_n;
    logic                     error_n;
    logic                     bus_cond;
    logic                     accept_en;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs; reset releases sda immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            byte_full   <= 1'b0;
            shift_reg   <= '0;
            ack_latched <= 1'b0;
            data        <= '0;
            sda_out     <= 1'b1;
            finish      <= 1'b0;
            error       <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_n;
            byte_full   <= byte_full_n;
            shift_reg   <= shift_reg_n;
            ack_latched <= ack_latched_n;
            data        <= data_n;
            sda_out     <= sda_out_n;
            finish      <= finish_n;
            error       <= error_n;
        end
    end

    // Next-state and next-output logic; bus START/STOP mid-byte aborts first,
    // which also guarantees finish and error are never raised together.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        byte_full_n   = byte_full;
        shift_reg_n   = shift_reg;
        ack_latched_n = ack_latched;
        data_n        = data;
        sda_out_n     = sda_out;
        finish_n      = 1'b0;
        error_n       = 1'b0;
        bus_cond      = start | stop;
        accept_en     = enable & !scl;

        case (state)
            ST_IDLE: begin
                sda_out_n = 1'b1;
                if (accept_en) begin
                    state_n       = ST_RECEIVE;
                    bit_cnt_n     = '0;
                    byte_full_n   = 1'b0;
                    shift_reg_n   = '0;
                    ack_latched_n = ack_enable;
                end
            end

            ST_RECEIVE: begin
                if (bus_cond) begin
                    error_n   = 1'b1;
                    sda_out_n = 1'b1;
                    state_n   = ST_IDLE;
                end else if (scl_rise && !byte_full) begin
                    shift_reg_n = shift_in_lsb(shift_reg, sda_in);
                    bit_cnt_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                        byte_full_n = 1'b1;
                    end
                end else if (scl_fall && byte_full) begin
                    data_n    = shift_reg;
                    sda_out_n = !ack_latched;
                    state_n   = ST_ACK;
                end
            end

            ST_ACK: begin
                if (bus_cond) begin
                    error_n   = 1'b1;
                    sda_out_n = 1'b1;
                    state_n   = ST_IDLE;
                end else if (scl_rise) begin
                    finish_n = 1'b1;
                    state_n  = ST_ACK_HOLD;
                end
            end

            ST_ACK_HOLD: begin
                if (bus_cond) begin
                    error_n   = 1'b1;
                    sda_out_n = 1'b1;
                    state_n   = ST_IDLE;
                end else if (scl_fall) begin
                    sda_out_n = 1'b1;
                    state_n   = ST_IDLE;
                    // Back-to-back byte: accept the next start on this same fall.
                    if (accept_en) begin
                        state_n       = ST_RECEIVE;
                        bit_cnt_n     = '0;
                        byte_full_n   = 1'b0;
                        shift_reg_n   = '0;
                        ack_latched_n = ack_enable;
                    end
                end
            end

            default: begin
                sda_out_n = 1'b1;
                state_n   = ST_IDLE;
            end
        endcase
    end

endmodule
